// File: rtl/iref_pwrup_seq.sv
// iref_pwrup_seq: bus initiator that powers the IREF reference up (pd=0, settle, charge pulse)
// and down (charge=0, pd=1) through single-beat writes on a valid/ready bus.
module iref_pwrup_seq #(
  parameter int unsigned ADDR_W        = 2,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned PD_ADDR       = 0,
  parameter int unsigned CHARGE_ADDR   = 1,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned CHARGE_CYCLES = 1000,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              shutdown,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              wstrb,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int unsigned MaxDly = (SETTLE_CYCLES > CHARGE_CYCLES) ? SETTLE_CYCLES
                                                                   : CHARGE_CYCLES;
  localparam int unsigned DlyW = $clog2(MaxDly + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
  localparam logic [DlyW-1:0] SettleLast = DlyW'(SETTLE_CYCLES - 1);
  localparam logic [DlyW-1:0] ChargeLast = DlyW'(CHARGE_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast     = ToW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StPdOff, StSettle, StChgOn, StCharge, StChgOff, StPdOn, StGap
  } state_e;

  state_e              state_q, state_d, ret_q, ret_d;
  logic                up_q, up_d;
  logic [DlyW-1:0]     dly_q, dly_d;
  logic [ToW-1:0]      wait_q, wait_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                issue;
  state_e              issue_tgt;

  function automatic logic [ADDR_W-1:0] wr_addr(state_e s);
    return (s == StPdOff || s == StPdOn) ? ADDR_W'(PD_ADDR) : ADDR_W'(CHARGE_ADDR);
  endfunction

  function automatic logic wr_val(state_e s);
    return (s == StChgOn || s == StPdOn);
  endfunction

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    up_d      = up_q;
    dly_d     = dly_q;
    wait_d    = wait_q;
    valid_d   = valid_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    err_d     = err_q;
    issue     = 1'b0;
    issue_tgt = StIdle;

    unique case (state_q)
      StIdle: begin
        if (shutdown) begin
          up_d      = 1'b0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          issue     = 1'b1;
          issue_tgt = StChgOff;
        end else if (start) begin
          up_d      = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          issue     = 1'b1;
          issue_tgt = StPdOff;
        end
      end
      StSettle: begin
        if (dly_q == SettleLast) begin
          issue     = 1'b1;
          issue_tgt = StChgOn;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      StCharge: begin
        if (dly_q == ChargeLast) begin
          issue     = 1'b1;
          issue_tgt = StChgOff;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      StGap: begin
        if (!ready) begin
          issue     = 1'b1;
          issue_tgt = ret_q;
        end
      end
      default: begin
        // Write states: valid is high here until ack or timeout.
        if (ready) begin
          valid_d = 1'b0;
          if (state_q == StPdOff) begin
            state_d = StSettle;
            dly_d   = '0;
          end else if (state_q == StChgOn) begin
            state_d = StCharge;
            dly_d   = '0;
          end else if (state_q == StChgOff && up_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (state_q == StChgOff) begin
            issue     = 1'b1;
            issue_tgt = StPdOn;
          end else begin
            state_d = StIdle;
          end
        end else if (wait_q == ToLast) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b0;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
    endcase

    // A new write only goes out once the previous ack has dropped; otherwise park in StGap.
    if (issue) begin
      address_d = wr_addr(issue_tgt);
      wdata_d   = DATA_W'(wr_val(issue_tgt));
      if (ready) begin
        state_d = StGap;
        ret_d   = issue_tgt;
        valid_d = 1'b0;
      end else begin
        state_d = issue_tgt;
        valid_d = 1'b1;
        wait_d  = '0;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ret_q     <= StIdle;
      up_q      <= 1'b0;
      dly_q     <= '0;
      wait_q    <= '0;
      valid_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      up_q      <= up_d;
      dly_q     <= dly_d;
      wait_q    <= wait_d;
      valid_q   <= valid_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign valid   = valid_q;
  assign wstrb   = valid_q;
  assign address = address_q;
  assign wdata   = wdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
